// File: rtl/gcd_iter_engine.sv
// Repeated-subtraction GCD engine driving an external combinational comparator.
// Latency: zero operand -> 1 cycle, else iter_count+2; holds the result while out_ready is low.
module gcd_iter_engine #(
    parameter int NUMBER_WIDTH = 16,
    parameter int MAX_ITER     = 65535,
    parameter int ITER_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUMBER_WIDTH-1:0] a_in,
    input  logic [NUMBER_WIDTH-1:0] b_in,
    output logic [NUMBER_WIDTH-1:0] comp1,
    output logic [NUMBER_WIDTH-1:0] comp2,
    input  logic [1:0]              cmp_result,
    input  logic [NUMBER_WIDTH-1:0] cmp_res,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUMBER_WIDTH-1:0] gcd_out,
    output logic [ITER_W-1:0]       iter_count,
    output logic                    err
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] CMP_GT = 2'd0;
    localparam logic [1:0] CMP_LT = 2'd1;
    localparam logic [1:0] CMP_EQ = 2'd2;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NUMBER_WIDTH-1:0] r_a;
    logic [NUMBER_WIDTH-1:0] r_b;
    logic [NUMBER_WIDTH-1:0] r_gcd;
    logic [NUMBER_WIDTH-1:0] w_a_nxt;
    logic [NUMBER_WIDTH-1:0] w_b_nxt;
    logic [NUMBER_WIDTH-1:0] w_gcd_nxt;
    logic [ITER_W-1:0]       r_iter;
    logic [ITER_W-1:0]       w_iter_nxt;
    logic                    r_err;
    logic                    w_err_nxt;
    logic                    w_timeout;

    assign w_timeout = (r_iter == ITER_W'(MAX_ITER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_gcd   <= '0;
            r_iter  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_gcd   <= w_gcd_nxt;
            r_iter  <= w_iter_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_gcd_nxt   = r_gcd;
        w_iter_nxt  = r_iter;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_a_nxt    = a_in;
                    w_b_nxt    = b_in;
                    w_iter_nxt = '0;
                    w_err_nxt  = 1'b0;
                    if ((a_in == '0) || (b_in == '0)) begin
                        w_gcd_nxt   = a_in | b_in;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                // Equality wins even on the last allowed step; otherwise the budget check stops subtraction.
                if (cmp_result == CMP_EQ) begin
                    w_gcd_nxt   = cmp_res;
                    w_state_nxt = ST_DONE;
                end else if (w_timeout) begin
                    w_gcd_nxt   = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (cmp_result == CMP_GT) begin
                    w_a_nxt    = r_a - r_b;
                    w_iter_nxt = r_iter + ITER_W'(1);
                end else if (cmp_result == CMP_LT) begin
                    w_b_nxt    = r_b - r_a;
                    w_iter_nxt = r_iter + ITER_W'(1);
                end else begin
                    w_gcd_nxt   = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign comp1      = r_a;
    assign comp2      = r_b;
    assign gcd_out    = r_gcd;
    assign iter_count = r_iter;
    assign err        = r_err;

endmodule

// File: tb/tb_gcd_iter_engine.sv
// Bench for gcd_iter_engine: behavioural GCD model, comparator model, per-cycle output monitor.
module tb_gcd_iter_engine;
    localparam int NW       = 16;
    localparam int MAX_ITER = 8;
    localparam int IW       = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] a_in;
    logic [NW-1:0] b_in;
    logic [NW-1:0] comp1;
    logic [NW-1:0] comp2;
    logic [1:0]    cmp_result;
    logic [NW-1:0] cmp_res;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] gcd_out;
    logic [IW-1:0] iter_count;
    logic          err;

    bit force_ne;
    int rdy_mode;
    int cyc;
    int n_cmp;
    int n_bad;

    typedef struct {
        logic [NW-1:0] g;
        int            it;
        bit            e;
        int            lat;
        int            acc;
    } exp_t;

    exp_t q[$];
    bit   seen;

    gcd_iter_engine #(
        .NUMBER_WIDTH(NW),
        .MAX_ITER    (MAX_ITER),
        .ITER_W      (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .comp1     (comp1),
        .comp2     (comp2),
        .cmp_result(cmp_result),
        .cmp_res   (cmp_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gcd_out   (gcd_out),
        .iter_count(iter_count),
        .err       (err)
    );

    // Combinational comparator, optionally forced to report "notequal".
    always_comb begin
        cmp_result = 2'd2;
        cmp_res    = comp1;
        if (force_ne)           cmp_result = 2'd3;
        else if (comp1 > comp2) cmp_result = 2'd0;
        else if (comp1 < comp2) cmp_result = 2'd1;
    end

    function automatic exp_t model(input logic [NW-1:0] a, input logic [NW-1:0] b,
                                   input bit ne, input int acc);
        exp_t          m;
        logic [NW-1:0] x;
        logic [NW-1:0] y;
        x = a;
        y = b;
        m.acc = acc;
        m.g   = '0;
        m.it  = 0;
        m.e   = 1'b0;
        if (a == 0 || b == 0) begin
            m.g   = a | b;
            m.lat = 1;
            return m;
        end
        if (ne) begin
            m.e   = 1'b1;
            m.lat = 2;
            return m;
        end
        while (1) begin
            if (x == y) begin
                m.g = x;
                break;
            end
            if (m.it == MAX_ITER) begin
                m.e = 1'b1;
                break;
            end
            if (x > y) x = x - y;
            else       y = y - x;
            m.it++;
        end
        m.lat = m.it + 2;
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                seen = 1'b0;
                continue;
            end
            chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() == 0});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = q[0];
                    chk("gcd_out", {16'd0, gcd_out}, {16'd0, e.g});
                    chk("iter_count", {16'd0, iter_count}, e.it);
                    chk("err", {31'd0, err}, {31'd0, e.e});
                    if (!seen) begin
                        chk("latency", cyc - e.acc, e.lat);
                        seen = 1'b1;
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(a_in, b_in, force_ne, cyc));
        end
    endtask

    task automatic send(input logic [NW-1:0] a, input logic [NW-1:0] b);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk("accept_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0) return;
        end
        chk("done_wait", q.size(), 32'd0);
    endtask

    initial begin
        exp_t m;
        logic [NW-1:0] ra;
        logic [NW-1:0] rb;
        clk      = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        out_ready = 1'b1;
        force_ne = 1'b0;
        rdy_mode = 0;
        cyc      = 0;
        n_cmp    = 0;
        n_bad    = 0;
        seen     = 1'b0;
        fork
            forever #5 clk = ~clk;
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(posedge clk);
                #1;
                if (rdy_mode == 0)      out_ready = 1'b1;
                else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
            end
            monitor();
        join_none

        // Hand-computed values pinning the model.
        m = model(16'd48, 16'd18, 1'b0, 0);
        chk("pin_48_18_gcd", {16'd0, m.g}, 32'd6);
        chk("pin_48_18_iter", m.it, 32'd4);
        chk("pin_48_18_lat", m.lat, 32'd6);
        m = model(16'd7, 16'd7, 1'b0, 0);
        chk("pin_7_7_lat", m.lat, 32'd2);
        m = model(16'd17, 16'd5, 1'b0, 0);
        chk("pin_17_5_gcd", {16'd0, m.g}, 32'd1);
        m = model(16'd0, 16'd5, 1'b0, 0);
        chk("pin_0_5_gcd", {16'd0, m.g}, 32'd5);
        m = model(16'd1, 16'd65535, 1'b0, 0);
        chk("pin_timeout_err", {31'd0, m.e}, 32'd1);
        chk("pin_timeout_iter", m.it, 32'd8);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_gcd", {16'd0, gcd_out}, 32'd0);
        chk("rst_iter", {16'd0, iter_count}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_comp1", {16'd0, comp1}, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send(16'd48, 16'd18);    wait_done();
        send(16'd7, 16'd7);      wait_done();
        send(16'd17, 16'd5);     wait_done();
        send(16'd0, 16'd5);      wait_done();
        send(16'd0, 16'd0);      wait_done();
        send(16'd1, 16'd65535);  wait_done();
        force_ne = 1'b1;
        send(16'd48, 16'd18);    wait_done();
        force_ne = 1'b0;

        // Backpressure: hold out_ready low for 10 cycles of valid output.
        rdy_mode = 2;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(16'd48, 16'd18);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
        repeat (10) @(negedge clk);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("bp_valid_after", {31'd0, out_valid}, 32'd0);
        rdy_mode = 0;

        // Asynchronous reset in the middle of a calculation.
        send(16'd48, 16'd18);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_iter", {16'd0, iter_count}, 32'd0);
        chk("arst_comp1", {16'd0, comp1}, 32'd0);
        chk("arst_comp2", {16'd0, comp2}, 32'd0);
        chk("arst_gcd", {16'd0, gcd_out}, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        send(16'd48, 16'd18);    wait_done();

        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            if (i % 15 == 7) rb = 16'($urandom_range(1000, 65535));
            force_ne = ($urandom_range(0, 9) == 0);
            send(ra, rb);
            wait_done();
            force_ne = 1'b0;
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
